upsample_2x_fp16: RTL and testbench
===================================

# upsample_2x_fp16

Nearest-neighbour 2x upsampler for the DFDD scale pyramid. It takes a half-resolution fp16 pixel stream, such as the first-scale output, and emits a full-resolution stream in which each input pixel is replicated into a 2x2 block. The output's col/row/valid timing can be aligned and added against zero-scale data. It is the inverse of the zero-scale downsample path, and sits between the first-scale stage and the dual-scale adder.

## Interface
- EXP_WIDTH, 5, fp exponent width
- FRAC_WIDTH, 10, fp fraction width
- IMAGE_WIDTH, none, full-resolution output width; must be even
- IMAGE_HEIGHT, none, full-resolution output height; must be even
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, pixel width (local)

Clocking: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- data_i  in  FP_WIDTH_REG  half-res pixel
- col_i  in  16  half-res column, 0..IMAGE_WIDTH/2-1
- row_i  in  16  half-res row, 0..IMAGE_HEIGHT/2-1
- valid_i  in  1  input pixel valid
- data_o  out  FP_WIDTH_REG  full-res pixel
- col_o  out  16  full-res column
- row_o  out  16  full-res row
- valid_o  out  1  output pixel valid
- overflow_o  out  1  sticky input-constraint violation flag

## Operation
- No backpressure. Input contract:
  - successive valid_i pulses are separated by at least 1 idle cycle;
  - after the last pixel of a half-res row, there are at least IMAGE_WIDTH+2 idle cycles before the next valid_i.
  - The downsampled stream satisfies this by construction.
- Line buffer: IMAGE_WIDTH/2 entries of FP_WIDTH_REG. Input pixel (c,r) is written at address c.
- FSM states:
  - S_IDLE: on accepted valid_i, register the pixel, write it to the line buffer, and go to S_DUP. If c == IMAGE_WIDTH/2-1, set the replay-pending flag.
  - S_DUP: emit the second copy. Next state is S_REPLAY if replay is pending, else S_IDLE.
  - S_REPLAY: emit row 2r+1 by reading line buffer address k>>1 for k = 0..IMAGE_WIDTH-1. Return to S_IDLE after k = IMAGE_WIDTH-1.
- Emission order for input (c,r):
  - (col 2c, row 2r) in the cycle after valid_i;
  - (2c+1, 2r) in the next cycle;
  - row 2r+1 in full during replay.
- Drops, with no output and no buffer write:
  - valid_i with col_i ≥ IMAGE_WIDTH/2 or row_i ≥ IMAGE_HEIGHT/2 is ignored silently.
  - valid_i arriving in S_DUP or S_REPLAY is dropped and sets overflow_o.
- Output coordinates: col_o = 2c + phase, row_o = 2r (+1 in replay). Use 16-bit arithmetic with no wrap, since the range is checked above.
- overflow_o clears only on rst_i.
- Data is copied bit-exact; no fp arithmetic is performed.

## Timing
- Reset (same cycle rst_i is sampled, effective at the next edge):
  - data_o, col_o, row_o, valid_o and overflow_o are all 0;
  - FSM goes to S_IDLE and replay-pending clears;
  - line buffer contents are don't-care.
  - Reset during S_REPLAY aborts the replay. No partial row is emitted after reset.
- Latency, input valid_i at cycle t:
  - first copy valid_o at t+1, second copy at t+2.
- Replay of row 2r+1:
  - starts at t_last+3, where t_last is the valid_i cycle of col IMAGE_WIDTH/2-1;
  - occupies IMAGE_WIDTH consecutive cycles with valid_o high.
- Line buffer read latency is 1 cycle. The replay address is issued in S_DUP of the last pixel, so replay output is gap-free.
- Line buffer write and replay read never collide under the contract. A violating write is dropped, so it cannot corrupt the replay.
- Boundary: when valid_i coincides with the final replay cycle (k = IMAGE_WIDTH-1), the pixel is dropped with overflow. It is accepted one cycle later.

## Structure
- Shared package dfdd_pkg:
  - FP_WIDTH_REG constants for fp16;
  - pixel-stream typedef (data, col, row, valid);
  - FSM state enum for upsample_2x_fp16.
- One sub-module: line_buffer_sdp, a simple dual-port RAM with 1-write/1-read and a 1-cycle registered read, parameterised by DATA_WIDTH and DEPTH.
- FSM, coordinate generation and output registers live in the top module.

## Test plan
All scenarios use IMAGE_WIDTH=8 and IMAGE_HEIGHT=4.
- Full frame: feed 4x2 half-res pixels with values 16'h3C00+idx, valid every 2nd cycle and 10 idle cycles between rows. Require 32 outputs, with (x,y) = input(x>>1, y>>1), in raster order.
- Latency: single pixel (0,0)=16'h4000 at cycle 5. Require valid_o at cycles 6 and 7 with col 0 and 1, row 0. Require no replay until col 3 arrives.
- Replay: after row 0 completes at cycle t, require valid_o high at t+3..t+10 with row_o=1, col_o 0..7, and data pairs repeated.
- Overflow: back-to-back valid_i at cycles 5 and 6. Require the second pixel dropped, overflow_o=1 from cycle 7, and the flag staying high until rst_i.
- Out-of-range: col_i=4 with valid_i. Require no valid_o, overflow_o stays 0.
- Reset mid-replay: assert rst_i at the 3rd replay cycle. Require all outputs 0 the next cycle, no further valid_o, and normal operation on a subsequent frame.

Source files
------------

// File: rtl/dfdd_pkg.sv
// Shared types and constants for the DFDD scale pyramid datapath.
// fp16 field widths, the pixel-stream record, and the upsampler FSM states.
// Pure declarations: no logic, no latency, no flow control.
package dfdd_pkg;

    localparam int FP16_EXP_WIDTH  = 5;
    localparam int FP16_FRAC_WIDTH = 10;
    localparam int FP16_WIDTH      = 1 + FP16_EXP_WIDTH + FP16_FRAC_WIDTH;
    localparam int COORD_WIDTH     = 16;

    // Coordinate pair, independent of the pixel payload width.
    typedef struct packed {
        logic [COORD_WIDTH-1:0] col;
        logic [COORD_WIDTH-1:0] row;
    } pix_pos_t;

    // One fp16 pixel-stream beat.
    typedef struct packed {
        logic [FP16_WIDTH-1:0]  data;
        logic [COORD_WIDTH-1:0] col;
        logic [COORD_WIDTH-1:0] row;
        logic                   valid;
    } pix_t;

    // Upsampler control states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DUP    = 2'd1,
        S_REPLAY = 2'd2
    } up_state_e;

endpackage

// File: rtl/line_buffer_sdp.sv
// Simple dual-port RAM: one write port, one read port, no reset on contents.
// Latency: write lands at the clock edge; read data is registered, valid 1 cycle after address.
// Backpressure: none; both ports accept a request every cycle.
module line_buffer_sdp #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 4,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  core_clk,
    input  logic                  wr_vld,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_vld,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store the pixel at its column address.
    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read port: registered output, holds its value when not reading.
    always_ff @(posedge core_clk) begin
        if (rd_vld) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/upsample_2x_fp16.sv
// Nearest-neighbour 2x upsampler: each half-res fp16 pixel becomes a 2x2 full-res block.
// Latency: copies at t+1 and t+2; odd row replayed gap-free from t_last+3 for IMAGE_WIDTH cycles.
// Backpressure: none; pixels arriving while busy are dropped and latch the sticky overflow flag.
module upsample_2x_fp16
    import dfdd_pkg::*;
#(
    parameter  int EXP_WIDTH    = FP16_EXP_WIDTH,
    parameter  int FRAC_WIDTH   = FP16_FRAC_WIDTH,
    parameter  int IMAGE_WIDTH  = 8,
    parameter  int IMAGE_HEIGHT = 4,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,
    output logic [FP_WIDTH_REG-1:0] data_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o,
    output logic                    overflow_o
);

    localparam int          HALF_W_INT = IMAGE_WIDTH / 2;
    localparam int          AW         = (HALF_W_INT > 1) ? $clog2(HALF_W_INT) : 1;
    localparam logic [15:0] HALF_W     = 16'(IMAGE_WIDTH / 2);
    localparam logic [15:0] HALF_H     = 16'(IMAGE_HEIGHT / 2);
    localparam logic [15:0] LAST_COL   = 16'(IMAGE_WIDTH / 2 - 1);
    localparam logic [15:0] LAST_K     = 16'(IMAGE_WIDTH - 1);

    // Control state.
    up_state_e state_q, state_d;
    logic      replay_pend_q, replay_pend_d;
    logic [15:0] k_q, k_d;

    // Pre-computed coordinates for the second copy and the replayed row.
    pix_pos_t  dup_pos_q, dup_pos_d;
    logic [15:0] rep_row_q, rep_row_d;

    // Output registers.
    logic [FP_WIDTH_REG-1:0] data_q, data_d;
    pix_pos_t                out_pos_q, out_pos_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;

    // Line buffer ports.
    logic                    lb_wr_vld;
    logic [AW-1:0]           lb_wr_addr;
    logic                    lb_rd_vld;
    logic [AW-1:0]           lb_rd_addr;
    logic [FP_WIDTH_REG-1:0] lb_rd_dat;

    logic in_range;

    assign in_range   = (col_i < HALF_W) && (row_i < HALF_H);
    assign lb_wr_addr = AW'(col_i);

    line_buffer_sdp #(
        .DATA_WIDTH (FP_WIDTH_REG),
        .DEPTH      (HALF_W_INT)
    ) u_line_buffer (
        .core_clk (clk_i),
        .wr_vld   (lb_wr_vld),
        .wr_addr  (lb_wr_addr),
        .wr_dat   (data_i),
        .rd_vld   (lb_rd_vld),
        .rd_addr  (lb_rd_addr),
        .rd_dat   (lb_rd_dat)
    );

    // Next-state, line-buffer control and next output values.
    always_comb begin
        state_d       = state_q;
        replay_pend_d = replay_pend_q;
        k_d           = k_q;
        dup_pos_d     = dup_pos_q;
        rep_row_d     = rep_row_q;
        data_d        = data_q;
        out_pos_d     = out_pos_q;
        valid_d       = 1'b0;
        ovf_d         = ovf_q;
        lb_wr_vld     = 1'b0;
        lb_rd_vld     = 1'b0;
        lb_rd_addr    = '0;

        unique case (state_q)
            S_IDLE: begin
                // Out-of-range pixels are ignored without touching any state.
                if (valid_i && in_range) begin
                    lb_wr_vld     = 1'b1;
                    data_d        = data_i;
                    out_pos_d.col = {col_i[14:0], 1'b0};
                    out_pos_d.row = {row_i[14:0], 1'b0};
                    valid_d       = 1'b1;
                    dup_pos_d.col = {col_i[14:0], 1'b1};
                    dup_pos_d.row = {row_i[14:0], 1'b0};
                    rep_row_d     = {row_i[14:0], 1'b1};
                    replay_pend_d = (col_i == LAST_COL);
                    state_d       = S_DUP;
                end
            end

            S_DUP: begin
                out_pos_d = dup_pos_q;
                valid_d   = 1'b1;
                if (valid_i) begin
                    ovf_d = 1'b1;
                end
                if (replay_pend_q) begin
                    // Prefetch the first replay word so replay output has no bubble.
                    lb_rd_vld     = 1'b1;
                    lb_rd_addr    = '0;
                    replay_pend_d = 1'b0;
                    k_d           = '0;
                    state_d       = S_REPLAY;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_REPLAY: begin
                data_d        = lb_rd_dat;
                out_pos_d.col = k_q;
                out_pos_d.row = rep_row_q;
                valid_d       = 1'b1;
                if (valid_i) begin
                    ovf_d = 1'b1;
                end
                if (k_q == LAST_K) begin
                    state_d = S_IDLE;
                end else begin
                    // Fetch the word for output column k+1, i.e. address (k+1)>>1.
                    lb_rd_vld  = 1'b1;
                    lb_rd_addr = AW'((k_q + 16'd1) >> 1);
                    k_d        = k_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any replay in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            replay_pend_q <= 1'b0;
            k_q           <= '0;
            dup_pos_q     <= '0;
            rep_row_q     <= '0;
            data_q        <= '0;
            out_pos_q     <= '0;
            valid_q       <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            replay_pend_q <= replay_pend_d;
            k_q           <= k_d;
            dup_pos_q     <= dup_pos_d;
            rep_row_q     <= rep_row_d;
            data_q        <= data_d;
            out_pos_q     <= out_pos_d;
            valid_q       <= valid_d;
            ovf_q         <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign col_o      = out_pos_q.col;
    assign row_o      = out_pos_q.row;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_upsample_2x_fp16.sv
// Bench for the 2x upsampler: directed scenarios plus randomized frames, all
// checked every cycle against a cycle-indexed expectation table built from the
// replication rules (2x2 block per pixel, odd row replayed from stored pixels).
module tb_upsample_2x_fp16;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int HW = W / 2;
    localparam int HH = H / 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] data_i = '0;
    logic [15:0] col_i = '0;
    logic [15:0] row_i = '0;
    logic        valid_i = 1'b0;
    logic [15:0] data_o;
    logic [15:0] col_o;
    logic [15:0] row_o;
    logic        valid_o;
    logic        overflow_o;

    upsample_2x_fp16 #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .col_i      (col_i),
        .row_i      (row_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .col_o      (col_o),
        .row_o      (row_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // ---------------- behavioural model: expectations keyed by cycle ----------
    logic [15:0] lb [HW];
    bit          ev [int];
    logic [15:0] ed [int];
    logic [15:0] ec [int];
    logic [15:0] er [int];
    bit          ez [int];
    bit          eo [int];
    int          busy_until = -1;
    int          arm_cyc = 1 << 30;

    function automatic void expect_beat(input int t, input logic [15:0] d,
                                        input int c, input int r);
        ev[t] = 1'b1;
        ed[t] = d;
        ec[t] = 16'(c);
        er[t] = 16'(r);
    endfunction

    // Pixel presented during cycle t.
    function automatic void model_pixel(input int t, input int c, input int r,
                                        input logic [15:0] d);
        if (t <= busy_until) begin
            eo[t+1] = 1'b1;
        end else if (c < HW && r < HH) begin
            lb[c] = d;
            expect_beat(t+1, d, 2*c, 2*r);
            expect_beat(t+2, d, 2*c+1, 2*r);
            if (c == HW-1) begin
                for (int k = 0; k < W; k++) expect_beat(t+3+k, lb[k>>1], k, 2*r+1);
                busy_until = t + 1 + W;
            end else begin
                busy_until = t + 1;
            end
        end
    endfunction

    // Reset presented during cycle n.
    function automatic void model_reset(input int n);
        for (int k = n+1; k < n+40; k++) begin
            if (ev.exists(k)) begin
                ev.delete(k); ed.delete(k); ec.delete(k); er.delete(k);
            end
            if (eo.exists(k)) eo.delete(k);
        end
        ez[n+1]    = 1'b1;
        eo[n+1]    = 1'b0;
        busy_until = n;
    endfunction

    // ---------------- compare process ----------------------------------------
    bit cur_ovf = 1'b0;
    always @(negedge clk) begin
        if (cyc >= arm_cyc) begin
            if (eo.exists(cyc)) cur_ovf = eo[cyc];
            chk("valid_o", {31'd0, valid_o}, {31'd0, ev.exists(cyc)});
            chk("overflow_o", {31'd0, overflow_o}, {31'd0, cur_ovf});
            if (ev.exists(cyc)) begin
                chk("data_o", {16'd0, data_o}, {16'd0, ed[cyc]});
                chk("col_o", {16'd0, col_o}, {16'd0, ec[cyc]});
                chk("row_o", {16'd0, row_o}, {16'd0, er[cyc]});
            end
            if (ez.exists(cyc)) begin
                chk("rst_data_o", {16'd0, data_o}, 32'd0);
                chk("rst_col_o", {16'd0, col_o}, 32'd0);
                chk("rst_row_o", {16'd0, row_o}, 32'd0);
            end
        end
    end

    // ---------------- full-frame raster monitor ------------------------------
    bit frame_on = 1'b0;
    int fcount = 0;
    always @(negedge clk) begin
        if (frame_on && valid_o === 1'b1) begin
            chk("frame_raster", 32'(row_o) * W + 32'(col_o), 32'(fcount));
            chk("frame_data", {16'd0, data_o},
                {16'd0, 16'h3C00 + 16'((row_o >> 1) * HW + (col_o >> 1))});
            fcount++;
        end
    end

    // ---------------- drivers ------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int c, input int r, input logic [15:0] d);
        step();
        rst_i   = 1'b0;
        valid_i = v;
        col_i   = 16'(c);
        row_i   = 16'(r);
        data_i  = d;
        if (v) model_pixel(cyc, c, r, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 16'h0);
    endtask

    task automatic do_reset();
        step();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        model_reset(cyc);
        if (arm_cyc > cyc + 1) arm_cyc = cyc + 1;
        drive(1'b0, 0, 0, 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int sel;

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_overflow", {31'd0, overflow_o}, 32'd0);
        chk("reset_data", {16'd0, data_o}, 32'd0);
        idle(3);

        // Latency of a single pixel, then the replay of row 1.
        drive(1'b1, 0, 0, 16'h4000);
        idle(1);
        @(negedge clk);
        chk("lat_first_valid", {31'd0, valid_o}, 32'd1);
        chk("lat_first_col", {16'd0, col_o}, 32'd0);
        chk("lat_first_data", {16'd0, data_o}, 32'h4000);
        idle(1);
        @(negedge clk);
        chk("lat_second_col", {16'd0, col_o}, 32'd1);
        chk("lat_second_row", {16'd0, row_o}, 32'd0);
        idle(5);
        for (int c = 1; c < HW; c++) begin
            drive(1'b1, c, 0, 16'h4000 + 16'(c));
            if (c != HW-1) idle(1);
        end
        idle(2);
        for (int k = 0; k < W; k++) begin
            idle(1);
            @(negedge clk);
            chk("replay_valid", {31'd0, valid_o}, 32'd1);
            chk("replay_row", {16'd0, row_o}, 32'd1);
            chk("replay_col", {16'd0, col_o}, 32'(k));
            chk("replay_data", {16'd0, data_o}, 32'h4000 + 32'(k >> 1));
        end
        idle(4);

        // Full frame in raster order.
        do_reset();
        fcount   = 0;
        frame_on = 1'b1;
        for (int r = 0; r < HH; r++) begin
            for (int c = 0; c < HW; c++) begin
                drive(1'b1, c, r, 16'h3C00 + 16'(r*HW + c));
                if (c == HW-1) idle(10);
                else idle(1);
            end
        end
        idle(2);
        frame_on = 1'b0;
        chk("frame_count", 32'(fcount), 32'(W*H));

        // Pixel on the final replay cycle is dropped; one cycle later is accepted.
        do_reset();
        for (int c = 0; c < HW; c++) begin
            drive(1'b1, c, 0, 16'h1000 + 16'(c));
            if (c != HW-1) idle(1);
        end
        idle(W);
        drive(1'b1, 0, 1, 16'h5555);
        drive(1'b1, 0, 1, 16'h6666);
        idle(1);
        @(negedge clk);
        chk("boundary_valid", {31'd0, valid_o}, 32'd1);
        chk("boundary_data", {16'd0, data_o}, 32'h6666);
        chk("boundary_row", {16'd0, row_o}, 32'd2);
        chk("boundary_overflow", {31'd0, overflow_o}, 32'd1);
        idle(4);

        // Back-to-back pixels: second is dropped, overflow is sticky until reset.
        do_reset();
        drive(1'b1, 1, 0, 16'h1111);
        drive(1'b1, 2, 0, 16'h2222);
        idle(1);
        @(negedge clk);
        chk("ovf_set", {31'd0, overflow_o}, 32'd1);
        chk("ovf_dup_col", {16'd0, col_o}, 32'd3);
        chk("ovf_dup_data", {16'd0, data_o}, 32'h1111);
        idle(20);
        @(negedge clk);
        chk("ovf_sticky", {31'd0, overflow_o}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("ovf_cleared", {31'd0, overflow_o}, 32'd0);

        // Out-of-range coordinates are ignored silently.
        drive(1'b1, HW, 0, 16'h7777);
        idle(1);
        drive(1'b1, 0, HH, 16'h7778);
        idle(3);
        @(negedge clk);
        chk("oor_valid", {31'd0, valid_o}, 32'd0);
        chk("oor_overflow", {31'd0, overflow_o}, 32'd0);

        // Reset during the third replay cycle aborts the replay.
        for (int c = 0; c < HW; c++) begin
            drive(1'b1, c, 0, 16'h2000 + 16'(c));
            if (c != HW-1) idle(1);
        end
        t = cyc;
        idle(3);
        do_reset();
        chk("abort_after_reset_cycle", 32'(cyc), 32'(t + 5));
        @(negedge clk);
        chk("abort_valid", {31'd0, valid_o}, 32'd0);
        chk("abort_col", {16'd0, col_o}, 32'd0);
        idle(12);
        for (int r = 0; r < HH; r++) begin
            for (int c = 0; c < HW; c++) begin
                drive(1'b1, c, r, 16'h3000 + 16'(r*HW + c));
                if (c == HW-1) idle(10);
                else idle(1);
            end
        end

        // Randomized frames with occasional violations, strays and a reset.
        for (int f = 0; f < 6; f++) begin
            for (int r = 0; r < HH; r++) begin
                for (int c = 0; c < HW; c++) begin
                    drive(1'b1, c, r, 16'($urandom));
                    sel = $urandom_range(0, 9);
                    if (sel == 0) begin
                        drive(1'b1, $urandom_range(0, HW-1), r, 16'($urandom));
                    end else if (sel == 1) begin
                        idle(1);
                        drive(1'b1, HW + $urandom_range(0, 3), r, 16'($urandom));
                    end
                    if (f == 3 && r == 1 && c == 1) do_reset();
                    if (c == HW-1) idle(10 + $urandom_range(0, 3));
                    else idle($urandom_range(1, 3));
                end
            end
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
